// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the write-back scheduler, the register file and decode.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; grant is combinational, the last-granted pointer moves only on accept.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant
);

    logic r_last;

    always_comb begin
        grant = valid;
        // On a tie the requester not granted last time wins.
        if (valid == 2'b11) begin
            grant = r_last ? 2'b01 : 2'b10;
        end
    end

    // Reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= 1'b1;
        end else if (accept) begin
            r_last <= grant[1];
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Write-back port scheduler and per-register pending-write scoreboard for the general-purpose register file.
module regfile_wb_sched
    import regfile_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              a_hazard,
    output logic              b_hazard,
    output logic              rf_rw,
    output logic [ADDR_W-1:0] rf_d_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic              sb_err
);

    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]        w_grant;
    logic              w_xfer;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_data;
    logic              w_inc;
    logic              w_underflow;

    logic              r_rf_rw_p1;
    logic [ADDR_W-1:0] r_rf_d_addr_p1;
    logic [DATA_W-1:0] r_rf_data_p1;
    logic [CNT_W-1:0]  r_cnt [NREG];
    logic              r_sb_err;

    // Saturating pending-count update; a simultaneous increment and decrement cancel.
    function automatic logic [CNT_W-1:0] cnt_next(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic             dec
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (inc && !dec && (cnt != CNT_MAX)) begin
            nxt = cnt + 1'b1;
        end else if (dec && !inc && (cnt != '0)) begin
            nxt = cnt - 1'b1;
        end
        return nxt;
    endfunction

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid  ({req1_valid, req0_valid}),
        .accept (w_xfer),
        .grant  (w_grant)
    );

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];
    assign w_xfer     = |w_grant;
    assign w_sel_addr = w_grant[1] ? req1_addr : req0_addr;
    assign w_sel_data = w_grant[1] ? req1_data : req0_data;

    assign issue_ready = (r_cnt[issue_addr] != CNT_MAX);
    assign w_inc       = issue_valid && issue_ready;
    assign a_hazard    = (r_cnt[a_addr] != '0);
    assign b_hazard    = (r_cnt[b_addr] != '0);

    // A commit into an empty counter is an error unless an issue to the same register cancels it.
    assign w_underflow = r_rf_rw_p1 && (r_cnt[r_rf_d_addr_p1] == '0) &&
                         !(w_inc && (issue_addr == r_rf_d_addr_p1));

    // ---- stage p1: write-port registers, committed by the register file at the next edge ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_rw_p1     <= 1'b0;
            r_rf_d_addr_p1 <= '0;
            r_rf_data_p1   <= '0;
        end else begin
            r_rf_rw_p1 <= w_xfer;
            if (w_xfer) begin
                r_rf_d_addr_p1 <= w_sel_addr;
                r_rf_data_p1   <= w_sel_data;
            end
        end
    end

    // ---- scoreboard: counters follow issues and the commit of the p1 write ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_sb_err <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= cnt_next(r_cnt[i],
                                     w_inc && (issue_addr == ADDR_W'(i)),
                                     r_rf_rw_p1 && (r_rf_d_addr_p1 == ADDR_W'(i)));
            end
            if (w_underflow) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    assign rf_rw     = r_rf_rw_p1;
    assign rf_d_addr = r_rf_d_addr_p1;
    assign rf_data   = r_rf_data_p1;
    assign sb_err    = r_sb_err;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched with a queue of expected register-file writes.
module tb_regfile_wb_sched;
    import regfile_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic [4:0]  a_addr, b_addr;
    logic        a_hazard, b_hazard;
    logic        rf_rw;
    logic [4:0]  rf_d_addr;
    logic [31:0] rf_data;
    logic        sb_err;

    int n_total = 0;
    int n_pass  = 0;
    wr_req_t exp_q[$];

    regfile_wb_sched dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .a_hazard    (a_hazard),
        .b_hazard    (b_hazard),
        .rf_rw       (rf_rw),
        .rf_d_addr   (rf_d_addr),
        .rf_data     (rf_data),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance one edge, then compare the write port against the scoreboard.
    task automatic step();
        wr_req_t e;
        @(posedge clk);
        #1;
        chk("rf_rw", rf_rw, exp_q.size() != 0);
        if (exp_q.size() != 0 && rf_rw === 1'b1) begin
            e = exp_q.pop_front();
            chk("rf_d_addr", rf_d_addr, e.addr);
            chk("rf_data", rf_data, e.data);
        end
    endtask

    task automatic push(input logic [4:0] addr, input logic [31:0] data);
        wr_req_t e;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [4:0] addr);
        issue_valid = 1'b1;
        issue_addr  = addr;
        #1;
        chk("issue_ready", issue_ready, 1'b1);
        step();
        issue_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_data = '0; req1_data = '0;
        issue_valid = 1'b0; issue_addr = '0;
        a_addr = '0; b_addr = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_rw", rf_rw, 1'b0);
        chk("rst_rf_d_addr", rf_d_addr, 5'd0);
        chk("rst_rf_data", rf_data, 32'd0);
        chk("rst_sb_err", sb_err, 1'b0);
        chk("rst_req0_ready", req0_ready, 1'b0);
        chk("rst_req1_ready", req1_ready, 1'b0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_a_hazard", a_hazard, 1'b0);
        rst_n = 1'b1;

        // Register the pending writes used by the first two tests.
        issue(5'd5);
        issue(5'd4);
        issue(5'd1);
        issue(5'd1);
        issue(5'd2);
        issue(5'd2);

        // Single request from requester 0.
        req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hA5A5_A5A5;
        #1;
        chk("t1_req0_ready", req0_ready, 1'b1);
        chk("t1_req1_ready", req1_ready, 1'b0);
        push(5'd5, 32'hA5A5_A5A5);
        step();
        req0_valid = 1'b0;
        #1;
        chk("t1_ready_drop", req0_ready, 1'b0);
        step();

        // Lone requester 1 makes it the last grant, so the tie run starts with 0.
        req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4444_0000;
        #1;
        chk("t2_req1_ready", req1_ready, 1'b1);
        push(5'd4, 32'h4444_0000);
        step();

        for (int i = 0; i < 4; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd1; req0_data = 32'h1000 + i;
            req1_valid = 1'b1; req1_addr = 5'd2; req1_data = 32'h2000 + i;
            #1;
            chk("t2_req0_ready", req0_ready, (i % 2) == 0);
            chk("t2_req1_ready", req1_ready, (i % 2) == 1);
            chk("t2_one_hot", req0_ready & req1_ready, 1'b0);
            if (i % 2 == 0) push(5'd1, 32'h1000 + i);
            else            push(5'd2, 32'h2000 + i);
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        a_addr = 5'd1; b_addr = 5'd2;
        #1;
        chk("t2_a_clear", a_hazard, 1'b0);
        chk("t2_b_clear", b_hazard, 1'b0);
        chk("t2_sb_err", sb_err, 1'b0);

        // Hazard on register 7 cleared by a requester-1 write.
        a_addr = 5'd7;
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("t3_a_before", a_hazard, 1'b0);
        step();
        issue_valid = 1'b0;
        chk("t3_a_set", a_hazard, 1'b1);
        step();
        chk("t3_a_hold", a_hazard, 1'b1);
        req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h7777_7777;
        #1;
        chk("t3_req1_ready", req1_ready, 1'b1);
        push(5'd7, 32'h7777_7777);
        step();
        req1_valid = 1'b0;
        chk("t3_a_cycle_n", a_hazard, 1'b1);
        step();
        chk("t3_a_cycle_n1", a_hazard, 1'b0);

        // Saturate register 3, try a fourth issue, then drain it.
        b_addr = 5'd3;
        issue_valid = 1'b1; issue_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_issue_ready", issue_ready, 1'b1);
            step();
        end
        chk("t4_saturated", issue_ready, 1'b0);
        step();
        issue_valid = 1'b0;
        chk("t4_b_hazard", b_hazard, 1'b1);
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h3300 + i;
            #1;
            chk("t4_req0_ready", req0_ready, 1'b1);
            push(5'd3, 32'h3300 + i);
            step();
        end
        req0_valid = 1'b0;
        chk("t4_b_last", b_hazard, 1'b1);
        step();
        chk("t4_b_clear", b_hazard, 1'b0);
        chk("t4_issue_free", issue_ready, 1'b1);
        chk("t4_sb_err", sb_err, 1'b0);

        // Write to register 9 with nothing pending.
        req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9999_9999;
        #1;
        chk("t5_req1_ready", req1_ready, 1'b1);
        push(5'd9, 32'h9999_9999);
        step();
        req1_valid = 1'b0;
        chk("t5_err_before", sb_err, 1'b0);
        step();
        chk("t5_err_set", sb_err, 1'b1);
        step();
        step();
        chk("t5_err_sticky", sb_err, 1'b1);

        // Reset while a write is on the port.
        a_addr = 5'd12;
        req0_valid = 1'b1; req0_addr = 5'd10; req0_data = 32'hDEAD_BEEF;
        issue_valid = 1'b1; issue_addr = 5'd12;
        push(5'd10, 32'hDEAD_BEEF);
        step();
        req0_valid = 1'b0; issue_valid = 1'b0;
        chk("t6_a_before", a_hazard, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6_rf_rw", rf_rw, 1'b0);
        chk("t6_rf_d_addr", rf_d_addr, 5'd0);
        chk("t6_rf_data", rf_data, 32'd0);
        chk("t6_sb_err", sb_err, 1'b0);
        chk("t6_a_hazard", a_hazard, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 5'd11; req0_data = 32'h0B0B_0B0B;
        req1_valid = 1'b1; req1_addr = 5'd13; req1_data = 32'h0D0D_0D0D;
        #1;
        chk("t6_tie_req0", req0_ready, 1'b1);
        chk("t6_tie_req1", req1_ready, 1'b0);
        push(5'd11, 32'h0B0B_0B0B);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
